// File: rtl/ldiv_pipe.sv
// Approximate float32 divider: a/b by subtracting magnitude bit patterns plus an offset.
// Two-stage valid/ready pipeline with clamping; define LDIV_NAN_EN for canonical NaN output.
module ldiv_pipe #(
    parameter logic [30:0] DIV_OFFSET = 31'h3F880000
) (
    input  logic        clk,
    input  logic        res,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    localparam logic [32:0] OVF_LIMIT = 33'h0_7F80_0000;
    localparam logic [30:0] MAG_INF   = 31'h7F800000;
    localparam logic [30:0] MAG_ZERO  = 31'h00000000;

    logic        stage1_adv_s;
    logic        stage2_adv_s;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_sign_q, s1_sign_d;
    logic [32:0] s1_sum_q, s1_sum_d;
    logic        s1_a_zero_q, s1_a_zero_d;
    logic        s1_b_zero_q, s1_b_zero_d;
    logic        s1_a_ff_q, s1_a_ff_d;
    logic        s1_b_ff_q, s1_b_ff_d;
`ifdef LDIV_NAN_EN
    logic        s1_nan_q, s1_nan_d;
`endif
    logic        out_valid_q, out_valid_d;
    logic [31:0] result_q, result_d;
    logic [31:0] clamp_s;

    // Handshake advance conditions, stage 1 operand capture and classification.
    always_comb begin
        stage2_adv_s = !out_valid_q || out_ready;
        stage1_adv_s = !s1_valid_q || stage2_adv_s;
        s1_valid_d   = s1_valid_q;
        s1_sign_d    = s1_sign_q;
        s1_sum_d     = s1_sum_q;
        s1_a_zero_d  = s1_a_zero_q;
        s1_b_zero_d  = s1_b_zero_q;
        s1_a_ff_d    = s1_a_ff_q;
        s1_b_ff_d    = s1_b_ff_q;
`ifdef LDIV_NAN_EN
        s1_nan_d     = s1_nan_q;
`endif
        if (stage1_adv_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d   = a[31] ^ b[31];
                s1_sum_d    = {2'b00, a[30:0]} - {2'b00, b[30:0]} + {2'b00, DIV_OFFSET};
                s1_a_zero_d = (a[30:23] == 8'h00);
                s1_b_zero_d = (b[30:23] == 8'h00);
                s1_a_ff_d   = (a[30:23] == 8'hFF);
                s1_b_ff_d   = (b[30:23] == 8'hFF);
`ifdef LDIV_NAN_EN
                s1_nan_d    = ((a[30:23] == 8'hFF) && (a[22:0] != 23'h0)) ||
                              ((b[30:23] == 8'hFF) && (b[22:0] != 23'h0)) ||
                              ((a[30:23] == 8'h00) && (b[30:23] == 8'h00)) ||
                              ((a[30:23] == 8'hFF) && (b[30:23] == 8'hFF));
`endif
            end else begin
                s1_sign_d = s1_sign_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Priority clamp of the stage 1 sum into the final float pattern.
    always_comb begin
        clamp_s = {s1_sign_q, s1_sum_q[30:0]};
        if (s1_a_zero_q) begin
            clamp_s = {s1_sign_q, MAG_ZERO};
        end else if (s1_b_zero_q) begin
            clamp_s = {s1_sign_q, MAG_INF};
        end else if (s1_a_ff_q) begin
            clamp_s = {s1_sign_q, MAG_INF};
        end else if (s1_b_ff_q) begin
            clamp_s = {s1_sign_q, MAG_ZERO};
        end else if (s1_sum_q[32]) begin
            clamp_s = {s1_sign_q, MAG_ZERO};
        end else if (s1_sum_q >= OVF_LIMIT) begin
            clamp_s = {s1_sign_q, MAG_INF};
        end else begin
            clamp_s = {s1_sign_q, s1_sum_q[30:0]};
        end
    end

    // Stage 2 result capture; result holds while stalled or when stage 1 is empty.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        if (stage2_adv_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
`ifdef LDIV_NAN_EN
                result_d = s1_nan_q ? 32'h7FC00000 : clamp_s;
`else
                result_d = clamp_s;
`endif
            end else begin
                result_d = result_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers with synchronous reset discarding all in-flight work.
    always_ff @(posedge clk) begin
        if (res) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_sum_q    <= 33'h0;
            s1_a_zero_q <= 1'b0;
            s1_b_zero_q <= 1'b0;
            s1_a_ff_q   <= 1'b0;
            s1_b_ff_q   <= 1'b0;
`ifdef LDIV_NAN_EN
            s1_nan_q    <= 1'b0;
`endif
            out_valid_q <= 1'b0;
            result_q    <= 32'h0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_sum_q    <= s1_sum_d;
            s1_a_zero_q <= s1_a_zero_d;
            s1_b_zero_q <= s1_b_zero_d;
            s1_a_ff_q   <= s1_a_ff_d;
            s1_b_ff_q   <= s1_b_ff_d;
`ifdef LDIV_NAN_EN
            s1_nan_q    <= s1_nan_d;
`endif
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign in_ready  = stage1_adv_s;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_ldiv_pipe.sv
// Scoreboard bench for ldiv_pipe: directed vectors, backpressure and mid-stream reset.
module tb_ldiv_pipe;

    logic        clk;
    logic        res;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int          checks;
    int          errors;
    int          n_acc;
    logic [31:0] sb[$];

    localparam int NV = 17;
    logic [31:0] va[NV];
    logic [31:0] vb[NV];
    logic [31:0] ve[NV];

    ldiv_pipe dut (
        .clk       (clk),
        .res       (res),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one operand pair; returns at posedge+1 after it is accepted.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] ev);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end else begin
            sb.push_back(ev);
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every output transfer is compared against the oldest expected value.
    always @(negedge clk) begin
        if (!res && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected none", result);
            end else begin
                check("result", result, sb.pop_front());
            end
        end
    end

    initial begin
        va[0]  = 32'h40C00000; vb[0]  = 32'h40000000; ve[0]  = 32'h40480000;
        va[1]  = 32'h3F800000; vb[1]  = 32'h3F800000; ve[1]  = 32'h3F880000;
        va[2]  = 32'hC0C00000; vb[2]  = 32'h40000000; ve[2]  = 32'hC0480000;
        va[3]  = 32'hC0C00000; vb[3]  = 32'hC0000000; ve[3]  = 32'h40480000;
        va[4]  = 32'h3F800000; vb[4]  = 32'h00000000; ve[4]  = 32'h7F800000;
        va[5]  = 32'h80000000; vb[5]  = 32'h40000000; ve[5]  = 32'h80000000;
        va[6]  = 32'h00800000; vb[6]  = 32'h7F000000; ve[6]  = 32'h00000000;
        va[7]  = 32'h7F000000; vb[7]  = 32'h00800000; ve[7]  = 32'h7F800000;
        va[8]  = 32'h3F800000; vb[8]  = 32'h80000000; ve[8]  = 32'hFF800000;
        va[9]  = 32'h00400000; vb[9]  = 32'h3F800000; ve[9]  = 32'h00000000;
        va[10] = 32'h3F800000; vb[10] = 32'h7F800000; ve[10] = 32'h00000000;
        va[11] = 32'h7F780000; vb[11] = 32'h3F800000; ve[11] = 32'h7F800000;
        va[12] = 32'h7F77FFFF; vb[12] = 32'h3F800000; ve[12] = 32'h7F7FFFFF;
        va[13] = 32'h00800000; vb[13] = 32'h4007FFFF; ve[13] = 32'h00000001;
`ifdef LDIV_NAN_EN
        va[14] = 32'h7FC00001; vb[14] = 32'h3F800000; ve[14] = 32'h7FC00000;
        va[15] = 32'h00000000; vb[15] = 32'h00000000; ve[15] = 32'h7FC00000;
        va[16] = 32'hFF800000; vb[16] = 32'h7F800000; ve[16] = 32'h7FC00000;
`else
        va[14] = 32'h7FC00001; vb[14] = 32'h3F800000; ve[14] = 32'h7F800000;
        va[15] = 32'h00000000; vb[15] = 32'h00000000; ve[15] = 32'h00000000;
        va[16] = 32'hFF800000; vb[16] = 32'h7F800000; ve[16] = 32'hFF800000;
`endif
    end

    initial begin
        int acc0;
        checks    = 0;
        errors    = 0;
        n_acc     = 0;
        res       = 1'b1;
        in_valid  = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        res = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", result, 32'h0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        send(va[0], vb[0], ve[0]);
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_cycle1_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("latency_cycle2_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            send(va[i], vb[i], ve[i]);
        end
        idle(4);

        out_ready = 1'b0;
        acc0      = n_acc;
        fork
            begin
                for (int j = 0; j < 4; j++) begin
                    send(va[j], vb[j], ve[j]);
                end
                in_valid = 1'b0;
            end
        join_none
        repeat (6) @(negedge clk);
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        check("full_accepts", n_acc - acc0, 32'd2);
        check("full_out_valid", {31'b0, out_valid}, 32'd1);
        check("full_result_hold", result, ve[0]);
        repeat (3) @(negedge clk);
        check("full_result_hold_later", result, ve[0]);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("drain_no_gap", {31'b0, out_valid}, 32'd1);
        end
        @(negedge clk);
        check("drain_end", {31'b0, out_valid}, 32'd0);
        wait fork;
        check("drain_accepts", n_acc - acc0, 32'd4);
        idle(2);

        out_ready = 1'b0;
        send(va[2], vb[2], ve[2]);
        send(va[3], vb[3], ve[3]);
        in_valid = 1'b0;
        res      = 1'b1;
        @(posedge clk);
        #1;
        res = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        check("midreset_result", result, 32'h0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(va[1], vb[1], ve[1]);
        in_valid = 1'b0;
        @(negedge clk);
        check("post_reset_cycle1_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("post_reset_cycle2_valid", {31'b0, out_valid}, 32'd1);
        idle(4);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
